// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO read-side streaming logic.
package fifo_pkg;

  localparam int unsigned BufDepth = 2;
  localparam int unsigned BufCntW  = 2;
  // buf_cnt + inflight reaches 3, so 3 bits keep the subtraction of pop from wrapping.
  localparam int unsigned CreditW  = 3;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry output buffer: push writes the tail, pop advances the head.
module stream_skid_buf
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  valid,
  output logic [BufCntW-1:0]    cnt
);

  logic [DATA_WIDTH-1:0] mem_q [BufDepth];
  logic [BufCntW-1:0]    cnt_q;
  logic                  push_ok;
  logic                  pop_ok;

  assign push_ok = push && (cnt_q != BufCntW'(BufDepth));
  assign pop_ok  = pop && (cnt_q != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      unique case ({push_ok, pop_ok})
        2'b10: begin
          mem_q[cnt_q[0]] <= push_data;
          cnt_q           <= cnt_q + BufCntW'(1);
        end
        2'b01: begin
          mem_q[0] <= mem_q[1];
          cnt_q    <= cnt_q - BufCntW'(1);
        end
        2'b11: begin
          // Count is unchanged; the new word lands behind whatever remains.
          if (cnt_q == BufCntW'(BufDepth)) begin
            mem_q[0] <= mem_q[1];
            mem_q[1] <= push_data;
          end else begin
            mem_q[0] <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head  = mem_q[0];
  assign valid = (cnt_q != '0);
  assign cnt   = cnt_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a non-show-ahead async FIFO read port into a valid/ready stream.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk_rd,
  input  logic                  rst_rd,
  input  logic                  fifo_empty_rd,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  rd_cnt
);

  logic                 inflight;
  logic                 pop;
  logic [BufCntW-1:0]   buf_cnt;
  logic [CreditW-1:0]   credit;

  assign pop = m_valid && m_ready;

  // Words held plus the word already requested, minus the one leaving this cycle.
  assign credit = CreditW'(buf_cnt) + CreditW'(inflight) - CreditW'(pop);
  assign rd_en  = !fifo_empty_rd && !rst_rd && (credit < CreditW'(BufDepth));

  always_ff @(posedge clk_rd or posedge rst_rd) begin
    if (rst_rd) begin
      inflight <= 1'b0;
      rd_cnt   <= '0;
    end else begin
      inflight <= rd_en;
      if (pop) begin
        rd_cnt <= rd_cnt + CNT_WIDTH'(1);
      end
    end
  end

  stream_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk      (clk_rd),
    .rst      (rst_rd),
    .push     (inflight),
    .push_data(rd_data),
    .pop      (pop),
    .head     (m_data),
    .valid    (m_valid),
    .cnt      (buf_cnt)
  );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench: FIFO read-port model feeding fifo_rd_stream, stream words collected and checked.
module tb_fifo_rd_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       fifo_empty_rd;
  logic       rd_en;
  logic [7:0] rd_data = 8'h00;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready;
  logic [15:0] rd_cnt;
  logic       rd_en4;
  logic       m_valid4;
  logic [7:0] m_data4;
  logic [3:0] rd_cnt4;

  always #5 clk = ~clk;

  fifo_rd_stream #(.DATA_WIDTH(8), .CNT_WIDTH(16)) u_dut (
    .clk_rd(clk), .rst_rd(rst), .fifo_empty_rd(fifo_empty_rd), .rd_en(rd_en),
    .rd_data(rd_data), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .rd_cnt(rd_cnt)
  );

  // Narrow-counter copy sees identical inputs; only its rd_cnt is checked.
  fifo_rd_stream #(.DATA_WIDTH(8), .CNT_WIDTH(4)) u_dut4 (
    .clk_rd(clk), .rst_rd(rst), .fifo_empty_rd(fifo_empty_rd), .rd_en(rd_en4),
    .rd_data(rd_data), .m_valid(m_valid4), .m_data(m_data4), .m_ready(m_ready), .rd_cnt(rd_cnt4)
  );

  // FIFO read-side model: not reset with the DUT, data valid one edge after rd_en.
  logic [7:0] mem [256];
  int wr_ptr;
  int rd_ptr = 0;
  assign fifo_empty_rd = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (rd_en && rd_ptr != wr_ptr) begin
      rd_data <= mem[rd_ptr];
      rd_ptr  <= rd_ptr + 1;
    end
  end

  logic [7:0] out_mem [512];
  int out_n = 0;
  int rd_en_n = 0;
  int empty_viol = 0;

  always @(posedge clk) begin
    if (m_valid && m_ready) begin
      out_mem[out_n] <= m_data;
      out_n          <= out_n + 1;
    end
    if (rd_en) rd_en_n <= rd_en_n + 1;
    if (rd_en && fifo_empty_rd) empty_viol <= empty_viol + 1;
  end

  int n_assert;
  int n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] v);
    mem[wr_ptr] = v;
    wr_ptr++;
  endtask

  task automatic rst_on();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic rst_off();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_words(input int base, input int n, input int bound);
    int cyc = 0;
    while (out_n - base < n && cyc < bound) begin
      @(negedge clk);
      cyc++;
    end
    check("word_count", 32'(out_n - base), 32'(n));
  endtask

  logic [5:0] en_tr;
  logic [5:0] v_tr;
  logic [7:0] d_tr [6];
  int base;
  int en_base;
  int cyc;
  logic any_valid;

  initial begin
    n_assert = 0;
    n_fail   = 0;
    wr_ptr   = 0;
    rst      = 1'b1;
    m_ready  = 1'b1;

    // Three preloaded words, consumer always ready.
    push_word(8'h11); push_word(8'h22); push_word(8'h33);
    repeat (2) @(negedge clk);
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_rd_cnt", 32'(rd_cnt), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      en_tr[i] = rd_en;
      v_tr[i]  = m_valid;
      d_tr[i]  = m_data;
      @(negedge clk);
    end
    check("s1_rd_en_trace", 32'(en_tr), 32'h07);
    check("s1_valid_trace", 32'(v_tr), 32'h1c);
    check("s1_data_c2", 32'(d_tr[2]), 32'h11);
    check("s1_data_c3", 32'(d_tr[3]), 32'h22);
    check("s1_data_c4", 32'(d_tr[4]), 32'h33);
    check("s1_rd_cnt", 32'(rd_cnt), 32'd3);

    // Ten words behind a 20-cycle stall.
    rst_on();
    m_ready = 1'b0;
    for (int k = 0; k < 10; k++) push_word(8'(k));
    base    = out_n;
    en_base = rd_en_n;
    rst_off();
    repeat (3) @(negedge clk);
    check("s2_data_early", 32'(m_data), 32'h00);
    repeat (17) @(negedge clk);
    check("s2_stall_rd_en", 32'(rd_en_n - en_base), 32'd2);
    check("s2_stall_valid", 32'(m_valid), 32'd1);
    check("s2_stall_data", 32'(m_data), 32'h00);
    check("s2_stall_nopop", 32'(out_n - base), 32'd0);
    m_ready = 1'b1;
    wait_words(base, 10, 60);
    for (int k = 0; k < 10; k++) check("s2_word", 32'(out_mem[base + k]), 32'(k));
    check("s2_rd_cnt", 32'(rd_cnt), 32'd10);

    // 100 words with m_ready alternating every cycle.
    rst_on();
    for (int k = 0; k < 100; k++) push_word(8'((k * 7 + 3) & 8'hff));
    base = out_n;
    rst_off();
    cyc = 0;
    while (out_n - base < 100 && cyc < 600) begin
      m_ready = ~m_ready;
      @(negedge clk);
      cyc++;
    end
    check("s3_word_count", 32'(out_n - base), 32'd100);
    for (int k = 0; k < 100; k++)
      check("s3_word", 32'(out_mem[base + k]), 32'((k * 7 + 3) & 8'hff));
    check("s3_rd_cnt", 32'(rd_cnt), 32'd100);
    check("s3_rd_cnt4", 32'(rd_cnt4), 32'd4);

    // Empty FIFO throughout.
    rst_on();
    m_ready = 1'b1;
    rst_off();
    en_base   = rd_en_n;
    any_valid = 1'b0;
    repeat (10) begin
      @(negedge clk);
      any_valid = any_valid | m_valid;
    end
    check("s4_no_rd_en", 32'(rd_en_n - en_base), 32'd0);
    check("s4_no_valid", 32'(any_valid), 32'd0);

    // Reset while the buffer holds two words.
    rst_on();
    m_ready = 1'b1;
    for (int k = 0; k < 7; k++) push_word(8'(8'ha0 + k));
    base = out_n;
    rst_off();
    wait_words(base, 2, 20);
    m_ready = 1'b0;
    repeat (6) @(negedge clk);
    check("s5_full_valid", 32'(m_valid), 32'd1);
    check("s5_full_head", 32'(m_data), 32'ha2);
    check("s5_full_cnt", 32'(rd_cnt), 32'd2);
    check("s5_full_rd_en", 32'(rd_en), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("s5_async_valid", 32'(m_valid), 32'd0);
    check("s5_async_cnt", 32'(rd_cnt), 32'd0);
    check("s5_async_data", 32'(m_data), 32'd0);
    check("s5_async_rd_en", 32'(rd_en), 32'd0);
    base = out_n;
    rst_off();
    m_ready = 1'b1;
    wait_words(base, 3, 30);
    check("s5_next_w4", 32'(out_mem[base]), 32'ha4);
    check("s5_next_w5", 32'(out_mem[base + 1]), 32'ha5);
    check("s5_next_w6", 32'(out_mem[base + 2]), 32'ha6);
    check("s5_rd_cnt", 32'(rd_cnt), 32'd3);

    // 17 words through the 4-bit counter copy.
    rst_on();
    m_ready = 1'b1;
    for (int k = 0; k < 17; k++) push_word(8'(8'h40 + k));
    base = out_n;
    rst_off();
    wait_words(base, 17, 60);
    check("s6_rd_cnt4_wrap", 32'(rd_cnt4), 32'd1);
    check("s6_rd_cnt", 32'(rd_cnt), 32'd17);
    check("s6_last_word", 32'(out_mem[base + 16]), 32'h50);

    check("rd_en_while_empty", 32'(empty_viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
